// File: rtl/tile_pkg.sv
// Shared tile-map constants and types for the write controller and the renderer.
package tile_pkg;

  localparam int unsigned MAP_COLS = 80;
  localparam int unsigned MAP_ROWS = 60;
  localparam int unsigned MAP_SIZE = MAP_COLS * MAP_ROWS;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned TILE_W   = 6;

  typedef logic [TILE_W-1:0] tile_id_t;
  typedef logic [ADDR_W-1:0] tile_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/tile_fill_engine.sv
// Linear fill engine: captures a fill command, clips it to the map and
// requests one write slot per tile until the run is exhausted.
module tile_fill_engine #(
  parameter int unsigned MAP_SIZE = tile_pkg::MAP_SIZE,
  parameter int unsigned ADDR_W   = tile_pkg::ADDR_W,
  parameter int unsigned TILE_W   = tile_pkg::TILE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_start_i,
  input  logic [ADDR_W-1:0] cmd_count_i,
  input  logic [TILE_W-1:0] cmd_tile_i,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [TILE_W-1:0] tile_o,
  output logic              busy_o,
  output logic              done_o
);
  import tile_pkg::*;

  localparam logic [ADDR_W-1:0] MapEnd = ADDR_W'(MAP_SIZE);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ADDR_W-1:0] space;

  // Next-state: accept, clip length to the map end, step one tile per grant
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    tile_d  = tile_q;
    space   = MapEnd - cmd_start_i;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cur_d  = cmd_start_i;
          tile_d = cmd_tile_i;
          if (cmd_start_i >= MapEnd) begin
            rem_d = '0;
          end else if (cmd_count_i < space) begin
            rem_d = cmd_count_i;
          end else begin
            rem_d = space;
          end
          state_d = (rem_d == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (gnt_i) begin
          rem_d = rem_q - 1'b1;
          // Hold cur on the final tile so it never points past the map
          if (rem_q == ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
            cur_d = cur_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any fill immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      tile_q  <= tile_d;
    end
  end

  // Status and request outputs decoded from state
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    req_o       = (state_q == FILL);
    busy_o      = (state_q == FILL);
    done_o      = (state_q == DONE);
    addr_o      = cur_q;
    tile_o      = tile_q;
  end

endmodule

// File: rtl/tile_map_ctrl.sv
// Write-side controller for the tile-ID map: round-robin arbitration between
// host single writes and the fill engine, with registered RAM write outputs.
module tile_map_ctrl #(
  parameter int unsigned MAP_SIZE    = tile_pkg::MAP_SIZE,
  parameter int unsigned ADDR_W      = tile_pkg::ADDR_W,
  parameter int unsigned TILE_W      = tile_pkg::TILE_W,
  parameter bit          VBLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [TILE_W-1:0] host_tile,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W-1:0] cmd_count,
  input  logic [TILE_W-1:0] cmd_tile,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [TILE_W-1:0] ram_wdata
);
  import tile_pkg::*;

  localparam logic [ADDR_W-1:0] MapEnd = ADDR_W'(MAP_SIZE);

  logic              en_q;
  logic              last_fill_q, last_fill_d;
  logic              eligible;
  logic              host_gnt, fill_gnt;
  logic              host_in_map;
  logic              fill_req, eng_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic [TILE_W-1:0] fill_tile;
  logic              ram_we_q, ram_we_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [TILE_W-1:0] wdata_q, wdata_d;

  tile_fill_engine #(
    .MAP_SIZE (MAP_SIZE),
    .ADDR_W   (ADDR_W),
    .TILE_W   (TILE_W)
  ) u_fill (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .cmd_valid_i (cmd_valid & en_q),
    .cmd_ready_o (eng_ready),
    .cmd_start_i (cmd_start),
    .cmd_count_i (cmd_count),
    .cmd_tile_i  (cmd_tile),
    .req_o       (fill_req),
    .gnt_i       (fill_gnt),
    .addr_o      (fill_addr),
    .tile_o      (fill_tile),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Arbitration: host wins unless the fill is pending and the host had the last slot
  always_comb begin
    eligible    = en_q & ((VBLANK_ONLY == 1'b0) | vblank);
    host_ready  = eligible & (~fill_req | last_fill_q);
    cmd_ready   = eng_ready & en_q;
    host_gnt    = host_valid & host_ready;
    fill_gnt    = eligible & fill_req & ~host_gnt;
    host_in_map = (host_addr < MapEnd);
    last_fill_d = last_fill_q;
    if (host_gnt) begin
      last_fill_d = 1'b0;
    end else if (fill_gnt) begin
      last_fill_d = 1'b1;
    end
  end

  // Next RAM write: address/data hold unless a real write is issued
  always_comb begin
    ram_we_d = 1'b0;
    drop_d   = host_gnt & ~host_in_map;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (host_gnt && host_in_map) begin
      ram_we_d = 1'b1;
      waddr_d  = host_addr;
      wdata_d  = host_tile;
    end else if (fill_gnt) begin
      ram_we_d = 1'b1;
      waddr_d  = fill_addr;
      wdata_d  = fill_tile;
    end
  end

  // Output and arbiter state registers; en_q keeps handshakes low until the
  // first clock after reset is released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q        <= 1'b0;
      last_fill_q <= 1'b1;
      ram_we_q    <= 1'b0;
      drop_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      en_q        <= 1'b1;
      last_fill_q <= last_fill_d;
      ram_we_q    <= ram_we_d;
      drop_q      <= drop_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign drop      = drop_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Directed bench for tile_map_ctrl: one free-running instance and one
// restricted to vertical blank.
module tb_tile_map_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vblank;
  logic        host_valid;
  logic [12:0] host_addr;
  logic [5:0]  host_tile;
  logic        cmd_valid;
  logic        vb_cmd_valid;
  logic [12:0] cmd_start;
  logic [12:0] cmd_count;
  logic [5:0]  cmd_tile;

  logic        host_ready, cmd_ready, busy, done, drop, ram_we;
  logic [12:0] ram_waddr;
  logic [5:0]  ram_wdata;
  logic        vb_host_ready, vb_cmd_ready, vb_busy, vb_done, vb_drop, vb_ram_we;
  logic [12:0] vb_ram_waddr;
  logic [5:0]  vb_ram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_map_ctrl #(.VBLANK_ONLY(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vblank     (vblank),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_tile  (host_tile),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_count  (cmd_count),
    .cmd_tile   (cmd_tile),
    .busy       (busy),
    .done       (done),
    .drop       (drop),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata)
  );

  tile_map_ctrl #(.VBLANK_ONLY(1'b1)) dut_vb (
    .clk        (clk),
    .reset_n    (reset_n),
    .vblank     (vblank),
    .host_valid (host_valid),
    .host_ready (vb_host_ready),
    .host_addr  (host_addr),
    .host_tile  (host_tile),
    .cmd_valid  (vb_cmd_valid),
    .cmd_ready  (vb_cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_count  (cmd_count),
    .cmd_tile   (cmd_tile),
    .busy       (vb_busy),
    .done       (vb_done),
    .drop       (vb_drop),
    .ram_we     (vb_ram_we),
    .ram_waddr  (vb_ram_waddr),
    .ram_wdata  (vb_ram_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    tick();
    host_valid = 1'b1; host_addr = 13'd100; host_tile = 6'd5;
    #3;
    reset_n = 1'b0;
    #1;
    outs = {ram_we, host_ready, cmd_ready, busy, done, drop, ram_waddr, ram_wdata};
    checks++;
    if (outs !== 25'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    outs = {vb_ram_we, vb_host_ready, vb_cmd_ready, vb_busy, vb_done, vb_drop,
            vb_ram_waddr, vb_ram_wdata};
    checks++;
    if (outs !== 25'd0) begin
      errors++; $display("FAIL reset_outputs_vb: got %h expected 0", outs);
    end
    tick();
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_no_we: got %b expected 0", ram_we);
    end
    host_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_host_only();
    host_valid = 1'b1; host_addr = 13'd2356; host_tile = 6'd12;
    checks++;
    if (host_ready !== 1'b1) begin
      errors++; $display("FAIL host_ready_idle: got %b expected 1", host_ready);
    end
    tick();
    host_valid = 1'b0;
    checks++;
    if ({ram_we, ram_waddr, ram_wdata} !== {1'b1, 13'd2356, 6'd12}) begin
      errors++;
      $display("FAIL host_write: got we=%b a=%0d d=%0d expected we=1 a=2356 d=12",
               ram_we, ram_waddr, ram_wdata);
    end
    tick();
    checks++;
    if ({ram_we, ram_waddr, ram_wdata} !== {1'b0, 13'd2356, 6'd12}) begin
      errors++;
      $display("FAIL host_pulse_hold: got we=%b a=%0d d=%0d expected we=0 a=2356 d=12",
               ram_we, ram_waddr, ram_wdata);
    end
  endtask

  task automatic test_fill_clip();
    int nw = 0;
    int nd = 0;
    logic [12:0] exp_a = 13'd4795;
    cmd_valid = 1'b1; cmd_start = 13'd4795; cmd_count = 13'd10; cmd_tile = 6'd11;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL fill_cmd_ready: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL fill_busy: got busy/ready=%b expected 10", {busy, cmd_ready});
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ram_we) begin
        checks++;
        if ({ram_waddr, ram_wdata} !== {exp_a, 6'd11}) begin
          errors++;
          $display("FAIL fill_write: got a=%0d d=%0d expected a=%0d d=11",
                   ram_waddr, ram_wdata, exp_a);
        end
        exp_a++;
        nw++;
      end
      if (done) nd++;
    end
    checks++;
    if (nw != 5) begin
      errors++; $display("FAIL fill_count: got %0d writes expected 5", nw);
    end
    checks++;
    if (nd != 1) begin
      errors++; $display("FAIL fill_done: got %0d done pulses expected 1", nd);
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL fill_idle: got ready/busy=%b expected 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_contention();
    int nw = 0;
    int hsent = 0;
    logic acc;
    logic [12:0] exp_a;
    logic [5:0]  exp_d;
    cmd_valid = 1'b1; cmd_start = 13'd0; cmd_count = 13'd8; cmd_tile = 6'd1;
    tick();
    cmd_valid = 1'b0;
    host_valid = 1'b1; host_addr = 13'd4000; host_tile = 6'd2;
    for (int c = 0; c < 40 && nw < 16; c++) begin
      acc = host_valid && host_ready;
      tick();
      if (ram_we) begin
        exp_a = (nw % 2 == 0) ? 13'(4000 + nw / 2) : 13'(nw / 2);
        exp_d = (nw % 2 == 0) ? 6'd2 : 6'd1;
        checks++;
        if ({ram_waddr, ram_wdata} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL contention_write%0d: got a=%0d d=%0d expected a=%0d d=%0d",
                   nw, ram_waddr, ram_wdata, exp_a, exp_d);
        end
        nw++;
      end
      if (acc) begin
        hsent++;
        if (hsent == 8) host_valid = 1'b0;
        else host_addr = 13'(4000 + hsent);
      end
    end
    host_valid = 1'b0;
    checks++;
    if (nw != 16) begin
      errors++; $display("FAIL contention_total: got %0d writes expected 16", nw);
    end
    tick();
    tick();
  endtask

  task automatic test_vblank();
    vblank = 1'b0;
    host_valid = 1'b1; host_addr = 13'd77; host_tile = 6'd9;
    checks++;
    if (vb_host_ready !== 1'b0) begin
      errors++; $display("FAIL vb_ready_low: got %b expected 0", vb_host_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (vb_ram_we !== 1'b0) begin
        errors++; $display("FAIL vb_no_write: got %b expected 0", vb_ram_we);
      end
    end
    vblank = 1'b1;
    #1;
    checks++;
    if (vb_host_ready !== 1'b1) begin
      errors++; $display("FAIL vb_ready_high: got %b expected 1", vb_host_ready);
    end
    tick();
    host_valid = 1'b0;
    vblank = 1'b0;
    checks++;
    if ({vb_ram_we, vb_ram_waddr, vb_ram_wdata} !== {1'b1, 13'd77, 6'd9}) begin
      errors++;
      $display("FAIL vb_first_write: got we=%b a=%0d d=%0d expected we=1 a=77 d=9",
               vb_ram_we, vb_ram_waddr, vb_ram_wdata);
    end
    tick();
  endtask

  task automatic test_edges();
    // Zero-length fill, then a fill starting past the map end
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1;
      cmd_start = (k == 0) ? 13'd10 : 13'd4800;
      cmd_count = (k == 0) ? 13'd0 : 13'd5;
      cmd_tile  = 6'd7;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({done, ram_we, busy} !== 3'b100) begin
        errors++;
        $display("FAIL edge_fill%0d_done: got done/we/busy=%b expected 100", k,
                 {done, ram_we, busy});
      end
      tick();
      checks++;
      if ({done, ram_we, cmd_ready} !== 3'b001) begin
        errors++;
        $display("FAIL edge_fill%0d_idle: got done/we/ready=%b expected 001", k,
                 {done, ram_we, cmd_ready});
      end
    end
    host_valid = 1'b1; host_addr = 13'd4800; host_tile = 6'd3;
    tick();
    host_valid = 1'b0;
    checks++;
    if ({drop, ram_we} !== 2'b10) begin
      errors++; $display("FAIL edge_drop: got drop/we=%b expected 10", {drop, ram_we});
    end
    tick();
    checks++;
    if ({drop, ram_we} !== 2'b00) begin
      errors++; $display("FAIL edge_drop_pulse: got drop/we=%b expected 00", {drop, ram_we});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    vblank = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_tile = '0;
    cmd_valid = 1'b0; vb_cmd_valid = 1'b0;
    cmd_start = '0; cmd_count = '0; cmd_tile = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    test_reset();
    test_host_only();
    test_fill_clip();
    test_contention();
    test_vblank();
    test_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
